// File: rtl/mix_round_sched_pkg.sv
// Shared types and helpers for the mix round scheduler: lane array, FSM states,
// seed expansion and digest folding.
package mix_round_sched_pkg;

   localparam int unsigned LANES = 8;
   localparam int unsigned W     = 32;

   typedef logic [W-1:0] lane_t;
   typedef lane_t lane_arr_t [LANES];

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   // Lane k starts at seed + k, wrapping mod 2^32.
   function automatic lane_arr_t seed_lanes(input lane_t seed);
      lane_arr_t l;
      for (int unsigned k = 0; k < LANES; k++) begin
         l[k] = seed + lane_t'(k);
      end
      return l;
   endfunction

   function automatic lane_t lanes_xor(input lane_arr_t l);
      lane_t acc;
      acc = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         acc = acc ^ l[k];
      end
      return acc;
   endfunction

   // A requested count of 0 stands for 16 rounds.
   function automatic logic [4:0] decode_rounds(input logic [3:0] r);
      return (r == 4'd0) ? 5'd16 : {1'b0, r};
   endfunction

endpackage

// File: rtl/mix_round_sched_if.sv
// Request/response bundle between the clients and the mix round scheduler.
// The master side issues jobs and consumes digests; the slave side is the scheduler.
interface mix_round_sched_if #(
   parameter int unsigned NREQ = 4
);
   import mix_round_sched_pkg::*;

   localparam int unsigned IdW = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_seed;
   logic [NREQ*4-1:0] req_rounds;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IdW-1:0]    rsp_id;
   logic [W-1:0]      rsp_data;

   modport master (
      output req_valid,
      output req_seed,
      output req_rounds,
      output rsp_ready,
      input  req_ready,
      input  rsp_valid,
      input  rsp_id,
      input  rsp_data
   );

   modport slave (
      input  req_valid,
      input  req_seed,
      input  req_rounds,
      input  rsp_ready,
      output req_ready,
      output rsp_valid,
      output rsp_id,
      output rsp_data
   );

endinterface

// File: rtl/mix_round.sv
// One mixing round over eight 32-bit lanes; purely combinational.
// Each step reads lanes already updated earlier in the same round.
module mix_round
   import mix_round_sched_pkg::*;
(
   input  lane_arr_t lanes_i,
   output lane_arr_t lanes_o
);

   lane_arr_t t;

   always_comb begin
      t    = lanes_i;
      t[0] = t[0] + t[7] - t[6];
      t[1] = t[1] + t[0] - t[7];
      t[2] = t[2] + t[1] - t[0];
      t[3] = t[3] + t[2] - t[1];
      t[4] = t[4] + t[3] - t[2];
      t[5] = t[5] + t[4] - t[3];
      t[6] = t[6] + t[5] - t[4];
      t[7] = t[7] + t[6] - t[5];
      lanes_o = t;
   end

endmodule

// File: rtl/mix_round_sched.sv
// Round-robin job scheduler in front of the single eight-lane mixing engine.
// Optional MIX_ROUND_SCHED_STATS_EN adds a 16-bit completed-job counter output.
module mix_round_sched
   import mix_round_sched_pkg::*;
#(
   parameter int unsigned NREQ = 4
) (
   input  logic             clk,
   input  logic             rst,
   mix_round_sched_if.slave bus,
   output logic             busy_o
`ifdef MIX_ROUND_SCHED_STATS_EN
   ,
   output logic [15:0]      job_count_o
`endif
);

   localparam int unsigned IdW = $clog2(NREQ);

   state_e          state_q;
   logic [IdW-1:0]  rr_q;
   logic [IdW-1:0]  owner_q;
   logic [4:0]      rounds_q;
   lane_arr_t       lanes_q;
   lane_arr_t       lanes_mixed;

   lane_t           seed_arr   [NREQ];
   logic [3:0]      rounds_arr [NREQ];
   logic [NREQ-1:0] gnt;
   logic [IdW-1:0]  gnt_idx, idx_hi, idx_lo, rr_next;
   logic            found_hi, found_lo, accept;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign seed_arr[i]   = bus.req_seed[i*W +: W];
      assign rounds_arr[i] = bus.req_rounds[i*4 +: 4];
   end

   // Round-robin: first valid at or above rr wins, else lowest valid below rr.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      idx_hi   = '0;
      idx_lo   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found_hi && bus.req_valid[i] && (IdW'(i) >= rr_q)) begin
            found_hi = 1'b1;
            idx_hi   = IdW'(i);
         end
         if (!found_lo && bus.req_valid[i]) begin
            found_lo = 1'b1;
            idx_lo   = IdW'(i);
         end
      end
      gnt_idx = found_hi ? idx_hi : idx_lo;
      rr_next = (gnt_idx == IdW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      accept  = (state_q == StIdle) && (found_hi || found_lo);
      for (int unsigned i = 0; i < NREQ; i++) begin
         gnt[i] = accept && (IdW'(i) == gnt_idx);
      end
   end

   assign bus.req_ready = gnt;

   mix_round u_mix_round (
      .lanes_i (lanes_q),
      .lanes_o (lanes_mixed)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         rr_q     <= '0;
         owner_q  <= '0;
         rounds_q <= '0;
         lanes_q  <= '{default: '0};
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  lanes_q  <= seed_lanes(seed_arr[gnt_idx]);
                  rounds_q <= decode_rounds(rounds_arr[gnt_idx]);
                  owner_q  <= gnt_idx;
                  rr_q     <= rr_next;
                  state_q  <= StRun;
               end
            end
            StRun: begin
               lanes_q  <= lanes_mixed;
               rounds_q <= rounds_q - 5'd1;
               if (rounds_q == 5'd1) begin
                  state_q <= StDone;
               end
            end
            StDone: begin
               if (bus.rsp_ready) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      bus.rsp_valid = (state_q == StDone);
      bus.rsp_id    = (state_q == StDone) ? owner_q : '0;
      bus.rsp_data  = (state_q == StDone) ? lanes_xor(lanes_q) : '0;
      busy_o        = (state_q != StIdle);
   end

`ifdef MIX_ROUND_SCHED_STATS_EN
   logic [15:0] job_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         job_count_q <= '0;
      end else if ((state_q == StDone) && bus.rsp_ready) begin
         job_count_q <= job_count_q + 16'd1;
      end
   end

   assign job_count_o = job_count_q;
`endif

endmodule

// File: tb/tb_mix_round_sched.sv
// Directed self-checking bench for mix_round_sched: single job, round encoding,
// contention order, backpressure, mid-run reset and (optionally) the job counter.
module tb_mix_round_sched;
   import mix_round_sched_pkg::*;

   localparam int unsigned NREQ = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
`ifdef MIX_ROUND_SCHED_STATS_EN
   logic [15:0] job_count;
`endif

   always #5 clk = ~clk;

   mix_round_sched_if #(.NREQ(NREQ)) bus_if ();

   mix_round_sched #(.NREQ(NREQ)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus_if),
      .busy_o (busy)
`ifdef MIX_ROUND_SCHED_STATS_EN
      ,
      .job_count_o (job_count)
`endif
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Independent reference: 3-bit lane indices wrap mod 8 on their own.
   function automatic logic [31:0] ref_digest(input logic [31:0] seed, input int rounds);
      logic [31:0] l [8];
      logic [2:0]  kk;
      logic [31:0] d;
      for (int k = 0; k < 8; k++) l[k] = seed + 32'(k);
      for (int r = 0; r < rounds; r++) begin
         for (int k = 0; k < 8; k++) begin
            kk    = 3'(k);
            l[kk] = l[kk] + l[kk - 3'd1] - l[kk - 3'd2];
         end
      end
      d = '0;
      for (int k = 0; k < 8; k++) d = d ^ l[k];
      return d;
   endfunction

   task automatic do_reset();
      rst                = 1'b1;
      bus_if.req_valid   = '0;
      bus_if.rsp_ready   = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic post_job(input int idx, input logic [31:0] seed, input logic [3:0] rnds);
      bus_if.req_seed[idx*32 +: 32]  = seed;
      bus_if.req_rounds[idx*4 +: 4]  = rnds;
      bus_if.req_valid[idx]          = 1'b1;
   endtask

   task automatic wait_rsp(output int cycles);
      cycles = 0;
      while (bus_if.rsp_valid !== 1'b1 && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
      check("rsp_seen", 32'(bus_if.rsp_valid), 32'd1);
   endtask

   logic [31:0] exp_lanes [8];
   logic [31:0] seeds [4];
   logic [3:0]  rnds [4];
   logic [31:0] exp_d;
   int          cyc;
   int          stray;
   int          g;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      exp_lanes = '{32'h1, 32'hFFFFFFFB, 32'hFFFFFFFC, 32'h4, 32'hC, 32'hD, 32'h7, 32'h1};
      seeds     = '{32'h0000_0011, 32'h8000_0000, 32'hFFFF_FFF0, 32'h0BAD_F00D};
      rnds      = '{4'd1, 4'd2, 4'd3, 4'd4};
      bus_if.req_valid  = '0;
      bus_if.req_seed   = '0;
      bus_if.req_rounds = '0;
      bus_if.rsp_ready  = 1'b1;

      // Reset values, sampled while reset is still asserted.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(bus_if.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      check("rst_rsp_id",    32'(bus_if.rsp_id),    32'd0);
      check("rst_rsp_data",  bus_if.rsp_data,       32'd0);
      check("rst_busy",      32'(busy),             32'd0);
      check("rst_lane0",     dut.lanes_q[0],        32'd0);
      rst = 1'b0;

      // Single job, seed 0, one round.
      post_job(0, 32'h0, 4'd1);
      #1 check("t1_req_ready", 32'(bus_if.req_ready), 32'b0001);
      @(negedge clk);
      bus_if.req_valid = '0;
      check("t1_busy_run", 32'(busy), 32'd1);
      wait_rsp(cyc);
      check("t1_cycles", 32'(cyc), 32'd1);
      check("t1_id",     32'(bus_if.rsp_id), 32'd0);
      check("t1_data",   bus_if.rsp_data, 32'h0000_0005);
      for (int k = 0; k < 8; k++) check($sformatf("t1_lane%0d", k), dut.lanes_q[k], exp_lanes[k]);
      @(negedge clk);
      check("t1_after_valid", 32'(bus_if.rsp_valid), 32'd0);
      check("t1_after_busy",  32'(busy), 32'd0);
      check("t1_after_data",  bus_if.rsp_data, 32'd0);

      // Round count 0 means 16; compare against 15.
      do_reset();
      post_job(1, 32'h1234_5678, 4'd0);
      @(negedge clk);
      bus_if.req_valid = '0;
      wait_rsp(cyc);
      check("t2_r0_cycles", 32'(cyc), 32'd16);
      check("t2_r0_id",     32'(bus_if.rsp_id), 32'd1);
      check("t2_r0_data",   bus_if.rsp_data, ref_digest(32'h1234_5678, 16));
      @(negedge clk);
      post_job(1, 32'h1234_5678, 4'd15);
      @(negedge clk);
      bus_if.req_valid = '0;
      wait_rsp(cyc);
      check("t2_r15_cycles", 32'(cyc), 32'd15);
      check("t2_r15_data",   bus_if.rsp_data, ref_digest(32'h1234_5678, 15));
      @(negedge clk);

      // Contention: all four requesters held valid.
      do_reset();
      for (int i = 0; i < 4; i++) post_job(i, seeds[i], rnds[i]);
      for (int j = 0; j < 5; j++) begin
         g = j % 4;
         #1 check($sformatf("t3_grant%0d", j), 32'(bus_if.req_ready), 32'(1) << g);
         @(negedge clk);
         wait_rsp(cyc);
         check($sformatf("t3_id%0d", j),   32'(bus_if.rsp_id), 32'(g));
         check($sformatf("t3_data%0d", j), bus_if.rsp_data, ref_digest(seeds[g], int'(rnds[g])));
         @(negedge clk);
      end
      bus_if.req_valid = '0;

      // Backpressure in DONE.
      do_reset();
      bus_if.rsp_ready = 1'b0;
      post_job(2, 32'hA5A5_A5A5, 4'd3);
      #1 check("t4_req_ready", 32'(bus_if.req_ready), 32'b0100);
      @(negedge clk);
      bus_if.req_valid = '0;
      wait_rsp(cyc);
      check("t4_cycles", 32'(cyc), 32'd3);
      exp_d = ref_digest(32'hA5A5_A5A5, 3);
      bus_if.req_valid = 4'b1111;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("t4_hold_valid", 32'(bus_if.rsp_valid), 32'd1);
         check("t4_hold_data",  bus_if.rsp_data, exp_d);
         check("t4_hold_id",    32'(bus_if.rsp_id), 32'd2);
         check("t4_hold_busy",  32'(busy), 32'd1);
         check("t4_hold_ready", 32'(bus_if.req_ready), 32'd0);
      end
      bus_if.rsp_ready = 1'b1;
      #1 check("t4_leave_ready", 32'(bus_if.req_ready), 32'd0);
      @(negedge clk);
      check("t4_done_valid", 32'(bus_if.rsp_valid), 32'd0);
      check("t4_done_busy",  32'(busy), 32'd0);
      check("t4_next_grant", 32'(bus_if.req_ready), 32'b1000);
      bus_if.req_valid = '0;

      // Reset while round 3 of 8 is being applied.
      do_reset();
      post_job(1, 32'hDEAD_BEEF, 4'd8);
      @(negedge clk);
      bus_if.req_valid = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t5_busy",      32'(busy), 32'd0);
      check("t5_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      check("t5_rsp_data",  bus_if.rsp_data, 32'd0);
      rst = 1'b0;
      bus_if.req_valid = 4'b1111;
      #1 check("t5_rr_zero", 32'(bus_if.req_ready), 32'b0001);
      bus_if.req_valid = '0;
      stray = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (bus_if.rsp_valid === 1'b1) stray++;
      end
      check("t5_no_stale", 32'(stray), 32'd0);

`ifdef MIX_ROUND_SCHED_STATS_EN
      do_reset();
      check("t6_cnt_rst", 32'(job_count), 32'd0);
      for (int j = 0; j < 3; j++) begin
         post_job(0, 32'(j), 4'd1);
         @(negedge clk);
         bus_if.req_valid = '0;
         wait_rsp(cyc);
         @(negedge clk);
      end
      check("t6_cnt3", 32'(job_count), 32'd3);
      force dut.job_count_q = 16'hFFFF;
      @(negedge clk);
      release dut.job_count_q;
      post_job(0, 32'h5, 4'd1);
      @(negedge clk);
      bus_if.req_valid = '0;
      wait_rsp(cyc);
      @(negedge clk);
      check("t6_cnt_wrap", 32'(job_count), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/mix_round_sched.md
# mix_round_sched

Shared scheduler and sequencer for the eight-lane 32-bit mixing datapath. Up to NREQ requesters submit seed jobs. A round-robin arbiter grants one job at a time, loads the lane registers, and runs the mix round once per clock for the requested count. It then returns a 32-bit digest through a valid/ready response port. It sits between the client blocks and the single mixing engine, so the engine is never driven by two clients at once.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, lane and seed width. Fixed at 32; other values are unsupported.

Ports:
- Clock and reset are the only decided interface items: one clock, named `clk`; reset named `rst`, synchronous and active-high.
- `clk`  in  1  sole clock; all state changes on the posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester job request.
- `req_ready`  out  NREQ  one-hot grant; a job is accepted when `req_valid[i] & req_ready[i]`.
- `req_seed`  in  NREQ*W  seed, requester i at bits [i*W +: W].
- `req_rounds`  in  NREQ*4  round count, requester i at [i*4 +: 4]; value 0 means 16 rounds.
- `rsp_valid`  out  1  digest available.
- `rsp_ready`  in  1  consumer accepts the digest.
- `rsp_id`  out  $clog2(NREQ)  index of the requester that owns the digest.
- `rsp_data`  out  W  digest.
- `busy`  out  1  high in RUN and DONE.

## Operation
- States:
  - IDLE: arbitrate.
  - RUN: one round per cycle.
  - DONE: hold the response.
- Lane load on accept: lane k = seed + k (mod 2^32), k = 0..7. Also capture the round count (0 becomes 16) and the owner id.
- Mix round: a sequential in-place chain, where each step uses lane values already updated earlier in the same round.
  - lane0 = lane0 + lane7 - lane6.
  - For k = 1..7: lane k = lane k + lane(k-1) - lane(k-2 mod 8).
  - All arithmetic is mod 2^32, unsigned wrap, with no saturation.
- Digest: the XOR of all eight lanes, driven combinationally in DONE and 0 in every other state.
- Arbitration: round-robin starting from pointer `rr`.
  - The grant goes to the first i with `req_valid[i]`, searching rr, rr+1, … mod NREQ.
  - After an accept, `rr` = granted index + 1, mod NREQ.
  - `req_ready` is 0 outside IDLE.
- Transitions:
  - IDLE→RUN on accept.
  - RUN→DONE on the edge that applies the final round.
  - DONE→IDLE on `rsp_valid & rsp_ready`.
  - No new job is accepted in the cycle that leaves DONE; arbitration resumes the following cycle.
- Boundaries:
  - Simultaneous requests: exactly one grant, following rr.
  - `rsp_ready` low: stay in DONE indefinitely, with `rsp_data` and `rsp_id` stable.
  - `req_valid` dropped after accept: no effect.
  - `rst` in any state: return to IDLE and discard the job; no response is produced.

## Timing
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0, `busy` = 0.
  - `rr` = 0, lanes = 0, round counter = 0.
- `req_ready` is combinational from `req_valid` and `rr` while in IDLE.
- Latency: accept on edge E0; rounds are applied on edges E1..ER; `rsp_valid` goes high in the cycle after ER. With R=1, `rsp_valid` is high in the cycle right after acceptance.
- Throughput: one job per R+2 cycles minimum (accept, R rounds, response handshake).

## Configuration
- `MIX_ROUND_SCHED_STATS_EN` defined: adds output `job_count` [15:0].
  - Reset value 0.
  - Increments on each response handshake; wraps from 0xFFFF to 0.
- `MIX_ROUND_SCHED_STATS_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `mix_round_sched_pkg`:
  - `LANES` = 8 and `W` = 32.
  - The state enum {IDLE, RUN, DONE}.
  - The lane array typedef (`lane_t [LANES]`).
- Sub-module `mix_round`: purely combinational, eight lanes in, eight lanes out, one round. The scheduler instantiates it once and registers its output while in RUN.

## Test plan
- Single job, requester 0 seed 0x0, rounds 1:
  - `req_ready[0]` is high in the same cycle.
  - One cycle later, `rsp_valid` = 1, `rsp_id` = 0, `rsp_data` = 0x00000005.
  - Intermediate lanes = 1, FFFFFFFB, FFFFFFFC, 4, C, D, 7, 1.
- Round-count encoding: rounds 0 versus rounds 15 on the same seed → `rsp_valid` arrives after 16 and 15 RUN cycles respectively, with digests matching the reference model.
- Contention, all four requesters valid continuously, rr = 0 → grants in order 0, 1, 2, 3, 0; each `rsp_id` matches its grant.
- Backpressure: hold `rsp_ready` low for 10 cycles in DONE →
  - `rsp_data` and `rsp_id` stay stable and `busy` stays 1;
  - no `req_ready` is asserted;
  - the handshake completes on the first cycle `rsp_ready` = 1.
- Reset mid-RUN, on round 3 of 8 →
  - next cycle: IDLE, `busy` = 0, `rsp_valid` = 0, `rr` = 0;
  - no stale response is produced later.
- With `MIX_ROUND_SCHED_STATS_EN`:
  - 3 completed jobs → `job_count` = 3;
  - preload the counter to 0xFFFF via a forced value, then complete one job → `job_count` = 0.
